// File: rtl/selftrigger_record_capture.sv
// Self-trigger record capture: keeps a circular pretrigger buffer, captures a record
// around each accepted trigger edge and streams a 5-word header plus the samples.
module selftrigger_record_capture #(
    parameter int          PRE_SAMPLES = 64,
    parameter int          RECORD_LEN  = 256,
    parameter int          DEPTH       = 512,
    parameter logic [7:0]  CHANNEL_ID  = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] y,
    input  logic               trigger,
    input  logic [63:0]        timestamp,
    output logic [15:0]        dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
    output logic [15:0]        dropped_count,
    output logic [1:0]         o_dbg_state
);
    localparam int AW   = $clog2(DEPTH);
    localparam int POST = RECORD_LEN - PRE_SAMPLES;
    localparam int CW   = $clog2(POST + 1);
    localparam int SW   = $clog2(PRE_SAMPLES + 2);
    localparam int NW   = RECORD_LEN + 5;
    localparam int WW   = $clog2(NW);

    localparam logic [AW-1:0] PRE_A    = AW'(PRE_SAMPLES);
    localparam logic [SW-1:0] PRE_S    = SW'(PRE_SAMPLES);
    localparam logic [CW-1:0] POST_M1  = CW'(POST - 1);
    localparam logic [WW-1:0] LAST_W   = WW'(NW - 1);
    localparam logic [WW-1:0] HDR_LAST = WW'(4);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HEADER, S_SEND} state_t;
    state_t r_state, w_next;

    logic [15:0]   r_mem [DEPTH];
    logic [15:0]   r_rd_q;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
    logic [SW-1:0] r_scnt;
    logic [CW-1:0] r_cap_cnt;
    logic [WW-1:0] r_widx;
    logic [63:0]   r_ts;
    logic [15:0]   r_dout, r_dropped, w_next_word;
    logic          r_valid, r_last, r_trig_hist;
    logic          w_evt, w_primed, w_write, w_accept, w_drop, w_to_header;
    logic          w_xfer, w_out_state, w_load_next, w_load_sample, w_done;

    // Handshake: a word moves when dout_valid && dout_ready; a presented word (and its
    // last flag) is held unchanged until accepted. r_rd_q always mirrors r_mem[r_rd_ptr].
    always_comb begin
        w_next        = r_state;
        w_to_header   = 1'b0;
        w_out_state   = (r_state == S_HEADER) || (r_state == S_SEND);
        w_write       = enable && ((r_state == S_IDLE) || (r_state == S_CAPTURE));
        w_evt         = enable && trigger && !r_trig_hist;
        w_primed      = (r_scnt >= PRE_S);
        w_accept      = w_evt && (r_state == S_IDLE) && w_primed;
        w_drop        = w_evt && !w_accept;
        w_xfer        = r_valid && dout_ready;
        w_load_next   = w_out_state && w_xfer && !r_last;
        w_done        = w_out_state && w_xfer && r_last;
        w_load_sample = w_load_next && (r_widx >= HDR_LAST);
        w_rd_ptr_n    = w_load_sample ? r_rd_ptr + AW'(1) : r_rd_ptr;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (POST == 1) begin
                        w_to_header = 1'b1;
                        w_next      = S_HEADER;
                    end else begin
                        w_next = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (enable && (r_cap_cnt == POST_M1)) begin
                    w_to_header = 1'b1;
                    w_next      = S_HEADER;
                end
            end
            S_HEADER: if (w_load_next && (r_widx == HDR_LAST)) w_next = S_SEND;
            S_SEND:   if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        if (r_widx == WW'(0))      w_next_word = r_ts[63:48];
        else if (r_widx == WW'(1)) w_next_word = r_ts[47:32];
        else if (r_widx == WW'(2)) w_next_word = r_ts[31:16];
        else if (r_widx == WW'(3)) w_next_word = r_ts[15:0];
        else                       w_next_word = r_rd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_scnt      <= '0;
            r_cap_cnt   <= '0;
            r_widx      <= '0;
            r_ts        <= '0;
            r_dout      <= '0;
            r_dropped   <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_trig_hist <= 1'b0;
        end else begin
            if (enable) r_trig_hist <= trigger;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_scnt   <= (r_scnt == PRE_S) ? r_scnt : r_scnt + SW'(1);
            end
            if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;

            if (w_accept) begin
                r_ts      <= timestamp;
                r_rd_ptr  <= r_wr_ptr - PRE_A;
                r_cap_cnt <= CW'(1);
            end else begin
                r_rd_ptr <= w_rd_ptr_n;
                if ((r_state == S_CAPTURE) && enable) r_cap_cnt <= r_cap_cnt + CW'(1);
            end

            if (w_to_header) begin
                r_valid <= 1'b1;
                r_last  <= 1'b0;
                r_dout  <= {8'hA5, CHANNEL_ID};
                r_widx  <= '0;
            end else if (w_load_next) begin
                r_dout <= w_next_word;
                r_widx <= r_widx + WW'(1);
                r_last <= ((r_widx + WW'(1)) == LAST_W);
            end else if (w_done) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_scnt  <= '0;
            end
        end
    end

    // Buffer storage carries no reset; contents are only trusted after priming.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= y;
        r_rd_q <= r_mem[w_rd_ptr_n];
    end

    assign dout          = r_dout;
    assign dout_valid    = r_valid;
    assign dout_last     = r_last;
    assign busy          = (r_state != S_IDLE);
    assign dropped_count = r_dropped;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_selftrigger_record_capture.sv
// Bench for selftrigger_record_capture: directed ramp records with literal checks plus
// a randomized run, all compared every cycle against a queue-based record model.
module tb_selftrigger_record_capture;
    localparam int PRE    = 64;
    localparam int RLEN   = 256;
    localparam int DEPTH  = 512;
    localparam int POST   = RLEN - PRE;
    localparam int NWORDS = RLEN + 5;
    localparam logic [7:0] CH = 8'h00;

    logic               clk = 1'b0;
    logic               reset, enable, trigger, dout_ready;
    logic signed [15:0] y;
    logic [63:0]        timestamp;
    logic [15:0]        dout, dropped_count;
    logic               dout_valid, dout_last, busy;
    logic [1:0]         dbg_state;

    selftrigger_record_capture #(
        .PRE_SAMPLES(PRE), .RECORD_LEN(RLEN), .DEPTH(DEPTH), .CHANNEL_ID(CH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .y(y), .trigger(trigger),
        .timestamp(timestamp), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy),
        .dropped_count(dropped_count), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, n = 0, tleft = 0;
    bit done;
    logic [63:0] ts_at_trig;

    // Model: 0 = waiting, 1 = collecting post-trigger samples, 2 = words outstanding.
    int          m_phase = 0, m_post_left = 0, m_scnt = 0, m_drop = 0;
    logic        m_prev = 1'b0;
    logic [63:0] m_ts;
    logic [15:0] m_hist[$];
    logic [15:0] m_rec[$];
    logic [15:0] exp_q[$];

    logic [15:0] log_w[$];
    logic        log_l[$];
    int          log_c[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_finish();
        exp_q.delete();
        exp_q.push_back({8'hA5, CH});
        exp_q.push_back(m_ts[63:48]);
        exp_q.push_back(m_ts[47:32]);
        exp_q.push_back(m_ts[31:16]);
        exp_q.push_back(m_ts[15:0]);
        foreach (m_rec[i]) exp_q.push_back(m_rec[i]);
        m_phase = 2;
    endtask

    task automatic model_edge();
        int ph;
        bit primed, evt;
        if (reset) begin
            m_phase = 0; m_scnt = 0; m_prev = 1'b0; m_drop = 0;
            m_hist.delete(); m_rec.delete(); exp_q.delete();
            return;
        end
        ph     = m_phase;
        primed = (m_scnt >= PRE);
        evt    = enable && trigger && !m_prev;
        if (enable) m_prev = trigger;
        if (evt && !(ph == 0 && primed) && m_drop < 65535) m_drop++;
        case (ph)
            0: if (enable) begin
                if (evt && primed) begin
                    m_rec = m_hist;
                    m_rec.push_back(y);
                    m_ts = timestamp;
                    m_post_left = POST - 1;
                    m_phase = 1;
                    if (m_post_left == 0) model_finish();
                end else begin
                    m_hist.push_back(y);
                    if (m_hist.size() > PRE) void'(m_hist.pop_front());
                    if (m_scnt < PRE) m_scnt++;
                end
            end
            1: if (enable) begin
                m_rec.push_back(y);
                m_post_left--;
                if (m_post_left == 0) model_finish();
            end
            default: if (dout_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_phase = 0; m_scnt = 0; m_hist.delete();
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_phase != 0);
        chk("dout_valid", dout_valid, m_phase == 2);
        chk("dropped_count", dropped_count, m_drop);
        if (m_phase == 2) begin
            chk("dout", dout, exp_q[0]);
            chk("dout_last", dout_last, exp_q.size() == 1);
        end
    endtask

    task automatic step();
        if (!reset && dout_valid && dout_ready) begin
            log_w.push_back(dout);
            log_l.push_back(dout_last);
            log_c.push_back(cyc);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        timestamp = timestamp + 64'd1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; trigger = 1'b0; y = '0; dout_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        n = 0;
        chk("rst_dout", dout, 16'h0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", dropped_count, 16'h0);
    endtask

    // Ramp y = sample number; one-sample trigger pulses at samples ta / tb2 and when
    // send_w words have gone out; optional 1010 backpressure and mid-record reset.
    task automatic ramp(input int ta, input int tb2, input int send_w, input bit bp,
                        input int rst_w, input int budget, output bit fin);
        bit seen;
        seen = 1'b0;
        fin  = 1'b0;
        log_w.delete(); log_l.delete(); log_c.delete();
        for (int k = 0; k < budget && !fin; k++) begin
            enable  = 1'b1;
            y       = 16'(n);
            trigger = (n == ta) || (n == tb2) ||
                      (send_w >= 0 && m_phase == 2 && log_w.size() == send_w);
            if (n == ta) ts_at_trig = timestamp;
            dout_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (rst_w >= 0 && log_w.size() == rst_w) begin
                reset = 1'b1;
                step();
                chk("midrst_valid", dout_valid, 1'b0);
                chk("midrst_busy", busy, 1'b0);
                reset = 1'b0;
                return;
            end
            n++;
            step();
            if (m_phase == 2) seen = 1'b1;
            if (seen && m_phase == 0) fin = 1'b1;
        end
    endtask

    task automatic check_rec(input string tag, input int first);
        int errs, lasts;
        errs = 0; lasts = 0;
        chk({tag, "_count"}, log_w.size(), NWORDS);
        if (log_w.size() == NWORDS) begin
            chk({tag, "_hdr0"}, log_w[0], 16'hA500);
            for (int i = 0; i < RLEN; i++)
                if (log_w[5 + i] !== 16'(first + i)) errs++;
            for (int i = 0; i < NWORDS - 1; i++)
                if (log_l[i]) lasts++;
            chk({tag, "_samples"}, errs, 0);
            chk({tag, "_first"}, log_w[5], first);
            chk({tag, "_final"}, log_w[NWORDS-1], first + RLEN - 1);
            chk({tag, "_lastflag"}, log_l[NWORDS-1], 1'b1);
            chk({tag, "_early_last"}, lasts, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        timestamp = {$urandom, $urandom};
        reset = 1'b1; enable = 1'b0; trigger = 1'b0; y = '0; dout_ready = 1'b1;

        // Basic capture
        do_reset();
        ramp(100, -1, -1, 1'b0, -1, 1000, done);
        chk("t1_done", done, 1'b1);
        check_rec("t1", 36);
        if (log_w.size() == NWORDS) begin
            chk("t1_ts3", log_w[1], ts_at_trig[63:48]);
            chk("t1_ts2", log_w[2], ts_at_trig[47:32]);
            chk("t1_ts1", log_w[3], ts_at_trig[31:16]);
            chk("t1_ts0", log_w[4], ts_at_trig[15:0]);
            chk("t1_contig", log_c[NWORDS-1] - log_c[0], NWORDS - 1);
        end

        // Not primed
        do_reset();
        ramp(10, -1, -1, 1'b0, -1, 40, done);
        chk("t2_no_record", done, 1'b0);
        chk("t2_dropped", dropped_count, 16'd1);
        chk("t2_busy", busy, 1'b0);
        chk("t2_no_words", log_w.size(), 0);

        // Busy rejection during capture and during send
        do_reset();
        ramp(100, 120, 150, 1'b0, -1, 1000, done);
        chk("t3_done", done, 1'b1);
        chk("t3_dropped", dropped_count, 16'd2);
        check_rec("t3", 36);

        // Backpressure
        do_reset();
        ramp(100, -1, -1, 1'b1, -1, 1500, done);
        chk("t4_done", done, 1'b1);
        check_rec("t4", 36);

        // Pointer wrap
        do_reset();
        ramp(500, -1, -1, 1'b0, -1, 1500, done);
        chk("t5_done", done, 1'b1);
        check_rec("t5", 436);

        // Mid-record reset, then re-priming
        do_reset();
        ramp(100, -1, -1, 1'b0, 55, 1000, done);
        n = 0;
        ramp(40, 64, -1, 1'b0, -1, 1000, done);
        chk("t6_done", done, 1'b1);
        chk("t6_dropped", dropped_count, 16'd1);
        check_rec("t6", 0);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            reset  = ($urandom_range(0, 2999) == 0);
            enable = ($urandom_range(0, 3) != 0);
            y      = 16'($urandom);
            if (tleft > 0) begin
                trigger = 1'b1;
                tleft--;
            end else if ($urandom_range(0, 79) == 0) begin
                trigger = 1'b1;
                tleft = $urandom_range(0, 400);
            end else begin
                trigger = 1'b0;
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; trigger = 1'b0; enable = 1'b1; dout_ready = 1'b1;
        for (int k = 0; k < 1500 && m_phase != 0; k++) step();
        chk("rnd_drain_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/selftrigger_record_capture.md
SELFTRIGGER_RECORD_CAPTURE -- requirements
Module: selftrigger_record_capture

Interface
REQ-001 SHALL have parameter PRE_SAMPLES, default 64, samples kept before the trigger sample.
REQ-002 SHALL have parameter RECORD_LEN, default 256, total samples per record, including pretrigger samples; PRE_SAMPLES < RECORD_LEN <= DEPTH.
REQ-003 SHALL have parameter DEPTH, default 512, sample buffer depth; a power of 2.
REQ-004 SHALL have parameter CHANNEL_ID, default 8'h00, channel tag placed in the header.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, sample strobe; y and trigger are valid only when enable=1.
REQ-008 SHALL have port y, input, 16, signed filtered sample from the self-trigger filter.
REQ-009 SHALL have port trigger, input, 1, self-trigger flag; may stay high for several samples.
REQ-010 SHALL have port timestamp, input, 64, free-running sample timestamp.
REQ-011 SHALL have port dout, output, 16, record stream word.
REQ-012 SHALL have port dout_valid, output, 1, dout holds a valid word.
REQ-013 SHALL have port dout_ready, input, 1, downstream accepts a word.
REQ-014 SHALL have port dout_last, output, 1, marks the final word of a record.
REQ-015 SHALL have port busy, output, 1, high in CAPTURE, HEADER and SEND.
REQ-016 SHALL have port dropped_count, output, 16, count of rejected triggers; saturates at 16'hFFFF.

Function
REQ-017 SHALL write y into a circular buffer at wr_ptr on every enable=1 cycle in IDLE and CAPTURE; wr_ptr wraps modulo DEPTH.
REQ-018 SHALL freeze buffer writes in HEADER and SEND.
REQ-019 SHALL count samples written since entering IDLE; primed=1 once that count >= PRE_SAMPLES.
REQ-020 SHALL define a trigger event as enable=1 with trigger=1, where trigger was 0 on the previous enable=1 cycle (rising edge in sample time).
REQ-021 SHALL, on a trigger event in IDLE with primed=1, latch timestamp and set start pointer = (wr_ptr - PRE_SAMPLES) mod DEPTH, the same-cycle y being record index PRE_SAMPLES; state -> CAPTURE.
REQ-022 SHALL, on a trigger event in any other case (not IDLE, or primed=0), increment dropped_count, saturating.
REQ-023 SHALL stay in CAPTURE until RECORD_LEN-PRE_SAMPLES samples have been written, the trigger sample included; the cycle after the last write, state -> HEADER.
REQ-024 SHALL emit 5 header words in HEADER: {8'hA5, CHANNEL_ID}, then timestamp[63:48], [47:32], [31:16], [15:0]; state -> SEND.
REQ-025 SHALL emit RECORD_LEN samples in SEND, oldest first, starting at the start pointer and wrapping modulo DEPTH; dout_last=1 only on the final sample.
REQ-026 SHALL transfer a word only when dout_valid=1 and dout_ready=1.
REQ-027 SHALL hold dout, dout_valid and dout_last stable while dout_valid=1 and dout_ready=0.
REQ-028 SHALL, with dout_ready held at 1, sustain one word per clock with no bubbles; this accounts for the 1-cycle buffer read latency.
REQ-029 SHALL assert dout_valid in the first HEADER cycle.
REQ-030 SHALL, when the final word transfers, go to IDLE with primed cleared and sample count reset to 0.
REQ-031 SHALL ignore enable and y for data purposes in HEADER and SEND; trigger events there still count as dropped.
REQ-032 SHALL make the edge detector track trigger in all states, so a trigger held high across the return to IDLE is not a new event.

Reset
REQ-033 SHALL, on reset=1, return to IDLE and force wr_ptr=0, sample count=0, primed=0, dropped_count=0, dout_valid=0, dout_last=0, dout=0, busy=0, and the edge-detect history to 0.
REQ-034 SHALL allow reset to abort any state mid-record: no further words are emitted, and buffer contents are don't-care.

Verification
REQ-035 SHALL cover basic capture: enable=1 continuously, y=ramp 0,1,2..., trigger pulse at sample 100, dout_ready=1, defaults -> header A500 + timestamp, then samples 36..291, dout_last on 291, 261 words contiguous.
REQ-036 SHALL cover pretrigger not primed: trigger at sample 10 after reset -> no record, dropped_count=1, busy=0.
REQ-037 SHALL cover busy rejection: second trigger edge 20 samples after the first, and another during SEND -> dropped_count=2, the first record is intact and unchanged.
REQ-038 SHALL cover backpressure: dout_ready toggling 1010... during SEND -> identical word sequence to REQ-035, with data stable while stalled.
REQ-039 SHALL cover wrap-around: DEPTH=512, trigger at sample 500 -> samples 436..691 emitted in order across the pointer wrap.
REQ-040 SHALL cover mid-record reset: reset asserted during SEND word 50 -> dout_valid=0 next cycle; a new record is accepted only after 64 new samples.
